// File: rtl/kernel_sram_ctrl.sv
// -----------------------------------------------------------------------------
// kernel_sram_ctrl
//
// Front-end controller for the dual-bank kernel SRAM. It streams a kernel-weight
// load into consecutive SRAM addresses and arbitrates each bank between that
// load stream and one PE read requester (rq0 -> bank 0, rq1 -> bank 1). The
// bank is selected by word-address bit 6. A read and a write never hit the
// same bank in the same cycle. A pending write is starved by same-bank reads
// for at most WR_STARVE consecutive cycles.
//
// Ports:
//   clk, rst                 clock (posedge) and synchronous active-high reset
//   ld_start_i/base_i/len_i  load command, sampled only while idle
//   wr_valid_i/data_i        write stream; wr_ready_o marks acceptance
//   ld_busy_o, ld_done_o     load in progress / one-cycle completion pulse
//   rqN_valid_i/addr_i       bank-N read request (address without bank bit)
//   rqN_ready_o              request granted this cycle
//   rqN_rvalid_o/rdata_o     read data, one cycle after grant
//   k_ren1_o/k_ra1_o         SRAM read port 1 (bank 0 requester)
//   k_ren2_o/k_ra2_o         SRAM read port 2 (bank 1 requester)
//   k_wen_o/k_wa_o/k_wd_o    SRAM write port
//   k_rd1_i, k_rd2_i         SRAM read data, valid one cycle after enable
// -----------------------------------------------------------------------------
module kernel_sram_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 64,
  parameter int WR_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start_i,
  input  logic [ADDR_W-1:0] ld_base_i,
  input  logic [ADDR_W:0]   ld_len_i,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  output logic              ld_busy_o,
  output logic              ld_done_o,
  input  logic              rq0_valid_i,
  input  logic [ADDR_W-2:0] rq0_addr_i,
  output logic              rq0_ready_o,
  output logic              rq0_rvalid_o,
  output logic [DATA_W-1:0] rq0_rdata_o,
  input  logic              rq1_valid_i,
  input  logic [ADDR_W-2:0] rq1_addr_i,
  output logic              rq1_ready_o,
  output logic              rq1_rvalid_o,
  output logic [DATA_W-1:0] rq1_rdata_o,
  output logic              k_ren1_o,
  output logic [ADDR_W-1:0] k_ra1_o,
  output logic              k_ren2_o,
  output logic [ADDR_W-1:0] k_ra2_o,
  output logic              k_wen_o,
  output logic [ADDR_W-1:0] k_wa_o,
  output logic [DATA_W-1:0] k_wd_o,
  input  logic [DATA_W-1:0] k_rd1_i,
  input  logic [DATA_W-1:0] k_rd2_i
);

  // Starve counters only need to reach WR_STARVE (at most 15).
  localparam int SC_W = 4;
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(WR_STARVE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [SC_W-1:0]   starve0_q, starve0_d;
  logic [SC_W-1:0]   starve1_q, starve1_d;
  logic              rq0_rvalid_q, rq1_rvalid_q;

  logic wr_pend;
  logic wr_bank;
  logic conf0, conf1;
  logic rd0_win, rd1_win;
  logic wr_accept;

  // ---------------------------------------------------------------------------
  // Bank arbitration
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before any condition, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_pend = (state_q == S_LOAD) && wr_valid_i;
    wr_bank = wr_addr_q[6];

    // A conflict is a pending write and a valid read on the same bank.
    conf0 = wr_pend && !wr_bank && rq0_valid_i;
    conf1 = wr_pend &&  wr_bank && rq1_valid_i;

    // The read keeps winning until the write has been held off WR_STARVE times.
    rd0_win = conf0 && (starve0_q < STARVE_MAX);
    rd1_win = conf1 && (starve1_q < STARVE_MAX);

    // Counters only advance while a read is actually blocking the write;
    // any other outcome (write wins, no conflict) restarts the count.
    starve0_d = rd0_win ? starve0_q + SC_W'(1) : '0;
    starve1_d = rd1_win ? starve1_q + SC_W'(1) : '0;

    rq0_ready_o = rq0_valid_i && (!conf0 || rd0_win);
    rq1_ready_o = rq1_valid_i && (!conf1 || rd1_win);
    wr_ready_o  = (state_q == S_LOAD) && !rd0_win && !rd1_win;
    wr_accept   = wr_valid_i && wr_ready_o;

    k_ren1_o = rq0_valid_i && rq0_ready_o;
    k_ren2_o = rq1_valid_i && rq1_ready_o;
    k_ra1_o  = {rq0_addr_i[ADDR_W-2:6], 1'b0, rq0_addr_i[5:0]};
    k_ra2_o  = {rq1_addr_i[ADDR_W-2:6], 1'b1, rq1_addr_i[5:0]};
    k_wen_o  = wr_accept;
    k_wa_o   = wr_addr_q;
    k_wd_o   = wr_data_i;
  end

  // ---------------------------------------------------------------------------
  // Load sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (ld_start_i) begin
          if (ld_len_i != '0) begin
            state_d     = S_LOAD;
            wr_addr_d   = ld_base_i;
            remaining_d = ld_len_i;
          end else begin
            // Zero-length load completes immediately without writing.
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (wr_accept) begin
          // Address wraps naturally at 2^ADDR_W.
          wr_addr_d   = wr_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (remaining_q == (ADDR_W+1)'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ld_busy_o = (state_q == S_LOAD);
  assign ld_done_o = (state_q == S_DONE);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_addr_q    <= '0;
      remaining_q  <= '0;
      starve0_q    <= '0;
      starve1_q    <= '0;
      rq0_rvalid_q <= 1'b0;
      rq1_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      remaining_q  <= remaining_d;
      starve0_q    <= starve0_d;
      starve1_q    <= starve1_d;
      rq0_rvalid_q <= k_ren1_o;
      rq1_rvalid_q <= k_ren2_o;
    end
  end

  // SRAM data arrives one cycle after the enable, aligned with rvalid.
  assign rq0_rvalid_o = rq0_rvalid_q;
  assign rq1_rvalid_o = rq1_rvalid_q;
  assign rq0_rdata_o  = k_rd1_i;
  assign rq1_rdata_o  = k_rd2_i;

endmodule

// File: tb/tb_kernel_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kernel_sram_ctrl
//
// Directed bench for kernel_sram_ctrl. Stimulus pushes hand-computed expected
// events (cycle, address, data) into queues; a monitor on the falling edge pops
// and compares whenever the DUT shows a write, a read grant, read data or a
// load-done pulse. A small SRAM model returns address-tagged read data.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_kernel_sram_ctrl;

  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW:0]   ld_len;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready, ld_busy, ld_done;
  logic          rq0_valid, rq0_ready, rq0_rvalid;
  logic [AW-2:0] rq0_addr;
  logic [DW-1:0] rq0_rdata;
  logic          rq1_valid, rq1_ready, rq1_rvalid;
  logic [AW-2:0] rq1_addr;
  logic [DW-1:0] rq1_rdata;
  logic          k_ren1, k_ren2, k_wen;
  logic [AW-1:0] k_ra1, k_ra2, k_wa;
  logic [DW-1:0] k_wd;
  logic [DW-1:0] k_rd1 = '0;
  logic [DW-1:0] k_rd2 = '0;

  always #5 clk = ~clk;

  kernel_sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WR_STARVE(4)) dut (
    .clk(clk), .rst(rst),
    .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_len_i(ld_len),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .ld_busy_o(ld_busy), .ld_done_o(ld_done),
    .rq0_valid_i(rq0_valid), .rq0_addr_i(rq0_addr), .rq0_ready_o(rq0_ready),
    .rq0_rvalid_o(rq0_rvalid), .rq0_rdata_o(rq0_rdata),
    .rq1_valid_i(rq1_valid), .rq1_addr_i(rq1_addr), .rq1_ready_o(rq1_ready),
    .rq1_rvalid_o(rq1_rvalid), .rq1_rdata_o(rq1_rdata),
    .k_ren1_o(k_ren1), .k_ra1_o(k_ra1), .k_ren2_o(k_ren2), .k_ra2_o(k_ra2),
    .k_wen_o(k_wen), .k_wa_o(k_wa), .k_wd_o(k_wd),
    .k_rd1_i(k_rd1), .k_rd2_i(k_rd2)
  );

  function automatic logic [DW-1:0] rdat(input logic [AW-1:0] a);
    return {16'hBEEF, 38'd0, a};
  endfunction

  function automatic logic [DW-1:0] wdat(input logic [7:0] id, input logic [AW-1:0] a);
    return {16'hDA7A, id, 30'd0, a};
  endfunction

  // SRAM read model: registered data, one cycle after enable.
  always @(posedge clk) begin
    if (k_ren1) k_rd1 <= rdat(k_ra1);
    if (k_ren2) k_rd2 <= rdat(k_ra2);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  ev_t wq[$];
  ev_t r0q[$];
  ev_t r1q[$];
  ev_t v0q[$];
  ev_t v1q[$];
  int  dq[$];

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  task automatic push_w(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wq.push_back('{c, a, d});
  endtask

  task automatic push_r0(input int c, input logic [AW-1:0] ra);
    r0q.push_back('{c, ra, '0});
    v0q.push_back('{c + 1, ra, rdat(ra)});
  endtask

  task automatic push_r1(input int c, input logic [AW-1:0] ra);
    r1q.push_back('{c, ra, '0});
    v1q.push_back('{c + 1, ra, rdat(ra)});
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares every DUT output event against the queued expectation.
  // ---------------------------------------------------------------------------
  ev_t me;
  int  md;
  always @(negedge clk) begin
    if (ld_busy) busy_cnt++;
    if (k_wen && (k_ren1 || k_ren2))
      check("bank_conflict", 64'((k_ren1 & ~k_wa[6]) | (k_ren2 & k_wa[6])), 64'(0));
    if (k_wen) begin
      if (wq.size() == 0) fail_now("unexpected_write");
      else begin
        me = wq.pop_front();
        check("wr_cycle", 64'(cyc), 64'(me.c));
        check("wr_addr", 64'(k_wa), 64'(me.addr));
        check("wr_data", k_wd, me.data);
      end
    end
    if (k_ren1) begin
      if (r0q.size() == 0) fail_now("unexpected_ren1");
      else begin
        me = r0q.pop_front();
        check("ren1_cycle", 64'(cyc), 64'(me.c));
        check("ra1", 64'(k_ra1), 64'(me.addr));
      end
    end
    if (k_ren2) begin
      if (r1q.size() == 0) fail_now("unexpected_ren2");
      else begin
        me = r1q.pop_front();
        check("ren2_cycle", 64'(cyc), 64'(me.c));
        check("ra2", 64'(k_ra2), 64'(me.addr));
      end
    end
    if (rq0_rvalid) begin
      if (v0q.size() == 0) fail_now("unexpected_rvalid0");
      else begin
        me = v0q.pop_front();
        check("rvalid0_cycle", 64'(cyc), 64'(me.c));
        check("rdata0", rq0_rdata, me.data);
      end
    end
    if (rq1_rvalid) begin
      if (v1q.size() == 0) fail_now("unexpected_rvalid1");
      else begin
        me = v1q.pop_front();
        check("rvalid1_cycle", 64'(cyc), 64'(me.c));
        check("rdata1", rq1_rdata, me.data);
      end
    end
    if (ld_done) begin
      if (dq.size() == 0) fail_now("unexpected_ld_done");
      else begin
        md = dq.pop_front();
        check("ld_done_cycle", 64'(cyc), 64'(md));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_start  = 1'b0;
    ld_base   = '0;
    ld_len    = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rq0_valid = 1'b0;
    rq0_addr  = '0;
    rq1_valid = 1'b0;
    rq1_addr  = '0;
  endtask

  // Issues a load from the current (idle) cycle, streams words with a proper
  // valid/ready handshake and optionally holds read requests until ld_done.
  task automatic do_load(input logic [7:0] id, input logic [AW-1:0] base,
                         input logic [AW:0] len,
                         input bit rd0, input logic [AW-2:0] a0,
                         input bit rd1, input logic [AW-2:0] a1);
    int sent   = 0;
    int budget = 0;
    bit done   = 1'b0;
    ld_start  = 1'b1;
    ld_base   = base;
    ld_len    = len;
    rq0_valid = rd0;
    rq0_addr  = a0;
    rq1_valid = rd1;
    rq1_addr  = a1;
    while (!done && budget < 64) begin
      wr_valid = (sent < int'(len));
      wr_data  = wdat(id, base + AW'(sent));
      @(negedge clk);
      if (wr_valid && wr_ready) sent++;
      if (ld_done) done = 1'b1;
      next();
      ld_start = 1'b0;
      budget++;
    end
    if (!done) fail_now("load_timeout");
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int c0;

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", 64'({wr_ready, ld_busy, ld_done, rq0_ready, rq0_rvalid,
                              rq1_ready, rq1_rvalid, k_ren1, k_ren2, k_wen}), 64'(0));
    check("reset_wa", 64'(k_wa), 64'(0));
    next();
    rst = 1'b0;
    next();

    // 1: plain load across the bank boundary at 0x040.
    busy_cnt = 0;
    c0 = cyc;
    push_w(c0 + 1, 10'h03E, wdat(8'd1, 10'h03E));
    push_w(c0 + 2, 10'h03F, wdat(8'd1, 10'h03F));
    push_w(c0 + 3, 10'h040, wdat(8'd1, 10'h040));
    push_w(c0 + 4, 10'h041, wdat(8'd1, 10'h041));
    dq.push_back(c0 + 5);
    do_load(8'd1, 10'h03E, 11'd4, 1'b0, '0, 1'b0, '0);
    check("t1_busy_cycles", 64'(busy_cnt), 64'(4));

    // 2: both requesters in idle, then a back-to-back rq0 grant.
    next();
    c0 = cyc;
    push_r0(c0, 10'h005);
    push_r1(c0, 10'h3C5);
    push_r0(c0 + 1, 10'h007);
    rq0_valid = 1'b1; rq0_addr = 9'h005;
    rq1_valid = 1'b1; rq1_addr = 9'h1C5;
    @(negedge clk);
    check("t2_ready_pair", 64'({rq0_ready, rq1_ready, wr_ready}), 64'(3'b110));
    next();
    rq1_valid = 1'b0;
    rq0_addr  = 9'h007;
    next();
    idle_inputs();
    next();

    // 3: bank-0 load against a persistent rq0: reads starve the write 4 times.
    c0 = cyc;
    for (int i = 0; i <= 11; i++)
      if (i != 5 && i != 10) push_r0(c0 + i, 10'h020);
    push_w(c0 + 5,  10'h010, wdat(8'd3, 10'h010));
    push_w(c0 + 10, 10'h011, wdat(8'd3, 10'h011));
    dq.push_back(c0 + 11);
    do_load(8'd3, 10'h010, 11'd2, 1'b1, 9'h020, 1'b0, '0);
    next();

    // 4: bank-0 load with rq1 active: no interaction, full rate on both.
    c0 = cyc;
    for (int i = 0; i <= 3; i++) push_r1(c0 + i, 10'h052);
    push_w(c0 + 1, 10'h010, wdat(8'd4, 10'h010));
    push_w(c0 + 2, 10'h011, wdat(8'd4, 10'h011));
    dq.push_back(c0 + 3);
    do_load(8'd4, 10'h010, 11'd2, 1'b0, '0, 1'b1, 9'h012);
    next();

    // 5a: zero-length load.
    c0 = cyc;
    dq.push_back(c0 + 1);
    do_load(8'd5, 10'h123, 11'd0, 1'b0, '0, 1'b0, '0);
    next();

    // 5b: address wrap from 0x3FF to 0x000.
    c0 = cyc;
    push_w(c0 + 1, 10'h3FF, wdat(8'd6, 10'h3FF));
    push_w(c0 + 2, 10'h000, wdat(8'd6, 10'h000));
    dq.push_back(c0 + 3);
    do_load(8'd6, 10'h3FF, 11'd2, 1'b0, '0, 1'b0, '0);
    next();

    // 7: bank-1 load starved by rq1 while rq0 (other bank) runs every cycle.
    c0 = cyc;
    for (int i = 0; i <= 6; i++) begin
      push_r0(c0 + i, 10'h001);
      if (i != 5) push_r1(c0 + i, 10'h040);
    end
    push_w(c0 + 5, 10'h040, wdat(8'd7, 10'h040));
    dq.push_back(c0 + 6);
    do_load(8'd7, 10'h040, 11'd1, 1'b1, 9'h001, 1'b1, 9'h000);
    next();

    // 6: reset after two of five words, then a fresh load from a new base.
    c0 = cyc;
    push_w(c0 + 1, 10'h100, wdat(8'd8, 10'h100));
    push_w(c0 + 2, 10'h101, wdat(8'd8, 10'h101));
    ld_start = 1'b1; ld_base = 10'h100; ld_len = 11'd5;
    wr_valid = 1'b1; wr_data = wdat(8'd8, 10'h100);
    next();
    ld_start = 1'b0;
    next();
    wr_data = wdat(8'd8, 10'h101);
    rst     = 1'b1;
    next();
    rst     = 1'b0;
    wr_data = wdat(8'd8, 10'h102);
    @(negedge clk);
    check("t6_after_reset", 64'({wr_ready, ld_busy, ld_done, k_wen}), 64'(0));
    next();
    idle_inputs();
    next();
    c0 = cyc;
    push_w(c0 + 1, 10'h200, wdat(8'd9, 10'h200));
    dq.push_back(c0 + 2);
    do_load(8'd9, 10'h200, 11'd1, 1'b0, '0, 1'b0, '0);

    repeat (3) next();
    check("left_writes", 64'(wq.size()), 64'(0));
    check("left_ren1", 64'(r0q.size()), 64'(0));
    check("left_ren2", 64'(r1q.size()), 64'(0));
    check("left_rvalid0", 64'(v0q.size()), 64'(0));
    check("left_rvalid1", 64'(v1q.size()), 64'(0));
    check("left_done", 64'(dq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kernel_sram_ctrl.md
Name: kernel_sram_ctrl

Overview:
Controller in front of the dual-bank kernel SRAM. It sequences kernel-weight loads from a write stream into consecutive SRAM addresses, and arbitrates each bank between the load stream and one PE read requester. The read requesters are rq0 for bank 0 and rq1 for bank 1. Bank select is address bit 6. The controller guarantees that no read and write ever hit the same bank in the same cycle, and that both read addresses always carry the correct bank bit.

Parameters:
ADDR_W, 10, kernel SRAM word address width; equals `KMEM_ADDR_WIDTH, must be >= 8.
DATA_W, 64, word width.
WR_STARVE, 4, maximum consecutive cycles a read may block a pending write on the same bank (range 1..15).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  reset; synchronous, active-high.
ld_start  in  1  start a load; sampled only in IDLE.
ld_base  in  ADDR_W  first write address; sampled with ld_start.
ld_len  in  ADDR_W+1  number of words to load; sampled with ld_start.
wr_valid  in  1  write data valid.
wr_data  in  DATA_W  write data.
wr_ready  out  1  write accepted this cycle when wr_valid=1.
ld_busy  out  1  high in LOAD state.
ld_done  out  1  one-cycle pulse at load completion.
rq0_valid  in  1  bank-0 read request.
rq0_addr  in  ADDR_W-1  bank-0 word address; bank bit excluded.
rq0_ready  out  1  request granted this cycle.
rq0_rvalid  out  1  read data valid.
rq0_rdata  out  DATA_W  read data.
rq1_valid, rq1_addr, rq1_ready, rq1_rvalid, rq1_rdata: same as rq0, for bank 1.
k_ren1  out  1  SRAM read enable, port 1.
k_ra1  out  ADDR_W  SRAM read address, port 1.
k_ren2  out  1  SRAM read enable, port 2.
k_ra2  out  ADDR_W  SRAM read address, port 2.
k_wen  out  1  SRAM write enable.
k_wa  out  ADDR_W  SRAM write address.
k_wd  out  DATA_W  SRAM write data.
k_rd1  in  DATA_W  SRAM read data, port 1; valid 1 cycle after k_ren1.
k_rd2  in  DATA_W  SRAM read data, port 2; valid 1 cycle after k_ren2.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; wr_addr, remaining, both starve counters and both rvalid registers cleared. All outputs are 0 during and after reset until a new event.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: on ld_start with ld_len!=0, latch wr_addr=ld_base and remaining=ld_len, then go to LOAD.
  - IDLE: on ld_start with ld_len=0, go to DONE with no writes.
  - LOAD: each accepted word (wr_valid & wr_ready) writes wr_addr, increments wr_addr modulo 2^ADDR_W, and decrements remaining. On acceptance with remaining=1, go to DONE.
  - DONE: ld_done=1 for exactly one cycle, then go to IDLE.
  - ld_start outside IDLE is ignored.
  - wr_ready=0 outside LOAD.
  - Reset mid-load returns to IDLE; no ld_done is issued.
- Read address mapping:
  - k_ra1 = {rq0_addr[ADDR_W-2:6], 1'b0, rq0_addr[5:0]}.
  - k_ra2 = {rq1_addr[ADDR_W-2:6], 1'b1, rq1_addr[5:0]}.
- Write bank wb = wr_addr[6]. A write is pending when state=LOAD & wr_valid.
- Arbitration, per bank b:
  - If a write is pending to b and rq_b_valid=1: grant the read (rq_b_ready=1, write stalled) while starve_b < WR_STARVE, and increment starve_b. Otherwise grant the write (wr_ready=1, rq_b_ready=0) and clear starve_b.
  - A write-only or read-only request is granted immediately and clears starve_b.
  - The bank not targeted by the write grants its read whenever valid.
- Outputs are combinational from grants:
  - k_ren1 = rq0_valid & rq0_ready; k_ren2 = rq1_valid & rq1_ready.
  - k_wen = wr_valid & wr_ready; k_wa = wr_addr; k_wd = wr_data.
- Read latency: rqN_rvalid is registered, asserting 1 cycle after grant. rqN_rdata = k_rd1 / k_rd2 passed through. Back-to-back grants give back-to-back rvalid.
- Invariant: never (k_ren1 & k_wen & ~k_wa[6]) or (k_ren2 & k_wen & k_wa[6]). Downstream read/write and two-address error flags must therefore stay 0.
- Requester address and valid must stay stable until ready; the write stream must stay stable until wr_ready.

Test Plan:
1. ld_base=0x03E, ld_len=4, wr_valid held high, no reads → writes to 0x03E, 0x03F, 0x040, 0x041 on 4 consecutive cycles. Bank switches at 0x040. ld_done pulses 1 cycle later; ld_busy=1 exactly 4 cycles.
2. rq0_addr=0x05, rq1_addr=0x1C5 both valid in IDLE → k_ra1=0x005, k_ra2=0x3C5. Both rvalid exactly 1 cycle later with SRAM data returned.
3. Load to bank 0 (ld_base=0x010, len=2) while rq0_valid held high, WR_STARVE=4 → 4 read grants, then write at 0x010 (rq0_ready=0 that cycle), then 4 read grants, then write 0x011. No cycle has k_ren1 & k_wen with k_wa[6]=0.
4. Same load while rq1_valid held high → writes at full rate (2 cycles), rq1 granted every cycle; no stalls on either side.
5. ld_len=0 → ld_done 1 cycle after ld_start, no k_wen. ld_base=0x3FF with len=2 → writes 0x3FF then 0x000.
6. rst asserted after 2 of 5 words → next cycle IDLE, wr_ready=0, ld_busy=0, no ld_done. A new ld_start then loads from its new ld_base.
